// File: rtl/serial_tx_pkg.sv
// Shared types and line levels for the serial transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a. Optional parity state present only with SERIAL_TX_PARITY_EN.
package serial_tx_pkg;

`ifdef SERIAL_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;
`endif

  // Serial line levels for the fixed framing bits.
  localparam logic LVL_IDLE  = 1'b1;
  localparam logic LVL_START = 1'b0;
  localparam logic LVL_STOP  = 1'b1;

endpackage

// File: rtl/serial_tx_tick.sv
// Bit-time boundary pulse generator: one pulse every DIV cycles while enabled.
// Latency: tick is high in the last cycle of each bit time (combinational from counter).
// Backpressure: none; clr holds the counter at zero so each frame starts aligned.
module serial_tx_tick #(
  parameter int DIV = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(DIV - 1));

  // Count 0..DIV-1 and wrap; held at zero while the transmitter is idle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/serial_tx.sv
// Parallel-to-serial transmitter: start bit, WIDTH data bits LSB first, optional even parity
// (SERIAL_TX_PARITY_EN), stop bit. Latency: start level on OUT the cycle after accept.
// Backpressure: DIN_READY high only in IDLE; DIN/DIN_VALID ignored while a frame is in flight.
module serial_tx #(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] DIN,
  input  logic             DIN_VALID,
  output logic             DIN_READY,
  output logic             OUT,
  output logic             BUSY
);

  import serial_tx_pkg::*;

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] sh_nxt;
  logic [BW-1:0]    bitcnt;
  logic             tick;
`ifdef SERIAL_TX_PARITY_EN
  logic             par;
`endif

  assign sh_nxt    = shreg >> 1;
  assign DIN_READY = (state == IDLE);

  serial_tx_tick #(
    .DIV (DIV)
  ) u_tick (
    .CLK  (CLK),
    .RST  (RST),
    .clr  (state == IDLE),
    .tick (tick)
  );

  // Frame sequencer; OUT and BUSY are registered alongside the state.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state  <= IDLE;
      OUT    <= LVL_IDLE;
      BUSY   <= 1'b0;
      shreg  <= '0;
      bitcnt <= '0;
`ifdef SERIAL_TX_PARITY_EN
      par    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (DIN_VALID) begin
            state  <= START;
            OUT    <= LVL_START;
            BUSY   <= 1'b1;
            shreg  <= DIN;
            bitcnt <= '0;
`ifdef SERIAL_TX_PARITY_EN
            // Parity is taken from the word as accepted, before shifting.
            par    <= ^DIN;
`endif
          end
        end
        START: begin
          if (tick) begin
            state <= DATA;
            OUT   <= shreg[0];
          end
        end
        DATA: begin
          if (tick) begin
            if (bitcnt == BW'(WIDTH - 1)) begin
`ifdef SERIAL_TX_PARITY_EN
              state <= PARITY;
              OUT   <= par;
`else
              state <= STOP;
              OUT   <= LVL_STOP;
`endif
            end else begin
              bitcnt <= bitcnt + BW'(1);
              shreg  <= sh_nxt;
              OUT    <= sh_nxt[0];
            end
          end
        end
`ifdef SERIAL_TX_PARITY_EN
        PARITY: begin
          if (tick) begin
            state <= STOP;
            OUT   <= LVL_STOP;
          end
        end
`endif
        STOP: begin
          if (tick) begin
            state <= IDLE;
            OUT   <= LVL_IDLE;
            BUSY  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          OUT   <= LVL_IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: two instances (DIV=4 and DIV=1) share one stimulus stream.
// A per-cycle expected-level queue per instance is built from accepted words.
module tb_serial_tx;

  localparam int W = 8;
`ifdef SERIAL_TX_PARITY_EN
  localparam int NB  = W + 3;
  localparam bit PAR = 1'b1;
`else
  localparam int NB  = W + 2;
  localparam bit PAR = 1'b0;
`endif

  logic         CLK;
  logic         RST;
  logic [W-1:0] din;
  logic         din_valid;
  logic         rdy4, out4, busy4;
  logic         rdy1, out1, busy1;

  int n_chk  = 0;
  int n_pass = 0;
  bit checking = 1'b0;

  // Expected OUT level for each upcoming cycle; empty queue means idle.
  bit q4[$];
  bit q1[$];

  serial_tx #(.WIDTH(W), .DIV(4)) dut4 (
    .CLK(CLK), .RST(RST), .DIN(din), .DIN_VALID(din_valid),
    .DIN_READY(rdy4), .OUT(out4), .BUSY(busy4)
  );

  serial_tx #(.WIDTH(W), .DIV(1)) dut1 (
    .CLK(CLK), .RST(RST), .DIN(din), .DIN_VALID(din_valid),
    .DIN_READY(rdy1), .OUT(out1), .BUSY(busy1)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Level of bit b within the frame carrying word w.
  function automatic bit frame_bit(input logic [W-1:0] w, input int b);
    if (b == 0) return 1'b0;
    if (b <= W) return w[b-1];
    if (PAR && b == W + 1) return ^w;
    return 1'b1;
  endfunction

  // Reference model: accept when idle, then play the frame out bit by bit.
  always @(posedge CLK or negedge RST) begin
    bit acc4, acc1;
    if (!RST) begin
      q4.delete();
      q1.delete();
    end else begin
      acc4 = din_valid && (q4.size() == 0);
      acc1 = din_valid && (q1.size() == 0);
      if (q4.size() != 0) void'(q4.pop_front());
      if (q1.size() != 0) void'(q1.pop_front());
      if (acc4) for (int b = 0; b < NB; b++) for (int c = 0; c < 4; c++) q4.push_back(frame_bit(din, b));
      if (acc1) for (int b = 0; b < NB; b++) q1.push_back(frame_bit(din, b));
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge CLK) begin
    if (checking) begin
      chk("out4",   out4,  (q4.size() != 0) ? q4[0] : 1'b1);
      chk("busy4",  busy4, q4.size() != 0);
      chk("ready4", rdy4,  q4.size() == 0);
      chk("out1",   out1,  (q1.size() != 0) ? q1[0] : 1'b1);
      chk("busy1",  busy1, q1.size() != 0);
      chk("ready1", rdy1,  q1.size() == 0);
    end
  end

  // Present w for one cycle; returns at the negedge of the first frame cycle.
  task automatic send(input logic [W-1:0] w);
    @(negedge CLK);
    din = w;
    din_valid = 1'b1;
    @(negedge CLK);
    din_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge CLK);
    while (!(rdy4 && rdy1) && n < 500) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 500) chk("idle_timeout", 0, 1);
  endtask

  initial begin
    logic          cap[0:59];
    logic [NB-1:0] lit;
    int            busyn;
    int            n;

    RST = 1'b0;
    din = '0;
    din_valid = 1'b0;
    repeat (3) @(negedge CLK);
    #2 RST = 1'b1;
    @(negedge CLK);
    checking = 1'b1;
    chk("rst_out4", out4, 1);
    chk("rst_busy4", busy4, 0);
    chk("rst_ready4", rdy4, 1);
    chk("rst_out1", out1, 1);

    // 0xA5 at DIV=4: sample mid-bit and count BUSY cycles.
`ifdef SERIAL_TX_PARITY_EN
    lit = {1'b1, 1'b0, 8'hA5, 1'b0};
`else
    lit = {1'b1, 8'hA5, 1'b0};
`endif
    send(8'hA5);
    busyn = 0;
    for (int i = 0; i < 60; i++) begin
      if (i > 0) @(negedge CLK);
      cap[i] = out4;
      busyn += int'(busy4);
    end
    chk("a5_busy_cycles", busyn, NB * 4);
    for (int k = 0; k < NB; k++) chk($sformatf("a5_bit%0d", k), cap[4*k+2], lit[k]);
    chk("a5_idle_after", cap[NB*4], 1);
    chk("a5_ready_after", rdy4, 1);

`ifdef SERIAL_TX_PARITY_EN
    wait_idle();
    send(8'h01);
    repeat (4 * (W + 1) + 2) @(negedge CLK);
    chk("par01_bit", out4, 1);
`endif

    // 0x3C at DIV=1: one cycle per bit.
    wait_idle();
`ifdef SERIAL_TX_PARITY_EN
    lit = {1'b1, 1'b0, 8'h3C, 1'b0};
`else
    lit = {1'b1, 8'h3C, 1'b0};
`endif
    send(8'h3C);
    for (int k = 0; k < NB; k++) begin
      if (k > 0) @(negedge CLK);
      chk($sformatf("div1_bit%0d", k), out1, lit[k]);
    end

    // Back-to-back frames with DIN_VALID held high.
    wait_idle();
    din = 8'h00;
    din_valid = 1'b1;
    @(negedge CLK);
    din = 8'hFF;
    n = 1;
    while (!rdy4 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    chk("b2b_busy_cycles", n - 1, NB * 4);
    chk("b2b_idle_out", out4, 1);
    chk("b2b_idle_busy", busy4, 0);
    @(negedge CLK);
    din_valid = 1'b0;
    chk("b2b_second_start", out4, 0);
    chk("b2b_second_busy", busy4, 1);

    // Asynchronous reset mid-frame, then a clean frame after release.
    wait_idle();
    send(8'h96);
    repeat (14) @(negedge CLK);
    #2 RST = 1'b0;
    #1;
    chk("arst_out", out4, 1);
    chk("arst_busy", busy4, 0);
    chk("arst_ready", rdy4, 1);
    @(negedge CLK);
    #2 RST = 1'b1;
    send(8'h5A);
    wait_idle();

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      @(negedge CLK);
      din = 8'($urandom);
      din_valid = ($urandom_range(0, 2) == 0);
    end
    @(negedge CLK);
    din_valid = 1'b0;
    wait_idle();
    @(negedge CLK);

    checking = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
